// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-port round-robin arbiter sharing one combinational ALU

module alu_arbiter_alu #(
    parameter int DWIDTH = 32
) (
    input  logic [3:0]        sel,
    input  logic [DWIDTH-1:0] a,
    input  logic [DWIDTH-1:0] b,
    output logic [DWIDTH-1:0] result
);

    // Decode on sel[2:0]; sel[3] picks sub over add and sra over srl.
    // Shifts use the full b, so amounts >= DWIDTH flush (or sign-fill for sra).
    always_comb begin
        result = '0;
        case (sel[2:0])
            3'b000: result = sel[3] ? (a - b) : (a + b);
            3'b001: result = a << b;
            3'b010: result = {{(DWIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            3'b011: result = {{(DWIDTH-1){1'b0}}, (a < b)};
            3'b100: result = a ^ b;
            3'b101: result = sel[3] ? DWIDTH'($signed(a) >>> b) : (a >> b);
            3'b110: result = a | b;
            3'b111: result = a & b;
            default: result = '0;
        endcase
    end

endmodule

module alu_arbiter #(
    parameter int DWIDTH = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [3:0]        req0_sel,
    input  logic [DWIDTH-1:0] req0_a,
    input  logic [DWIDTH-1:0] req0_b,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [DWIDTH-1:0] rsp0_data,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [3:0]        req1_sel,
    input  logic [DWIDTH-1:0] req1_a,
    input  logic [DWIDTH-1:0] req1_b,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DWIDTH-1:0] rsp1_data,
    output logic [15:0]       grant_cnt0,
    output logic [15:0]       grant_cnt1
);

    logic              prio;
    logic              elig0;
    logic              elig1;
    logic              grant0;
    logic              grant1;
    logic [3:0]        alu_sel;
    logic [DWIDTH-1:0] alu_a;
    logic [DWIDTH-1:0] alu_b;
    logic [DWIDTH-1:0] alu_result;

    // A port competes only when its response slot is empty or draining this
    // cycle; ties go to prio. Gating with rst_n keeps ready low during reset.
    always_comb begin
        elig0  = rst_n & req0_valid & (~rsp0_valid | rsp0_ready);
        elig1  = rst_n & req1_valid & (~rsp1_valid | rsp1_ready);
        grant0 = elig0 & (~elig1 | ~prio);
        grant1 = elig1 & (~elig0 | prio);
        req0_ready = grant0;
        req1_ready = grant1;
    end

    // Port 0 drives the ALU whenever port 1 is not granted; idle results are dropped.
    always_comb begin
        alu_sel = grant1 ? req1_sel : req0_sel;
        alu_a   = grant1 ? req1_a   : req0_a;
        alu_b   = grant1 ? req1_b   : req0_b;
    end

    alu_arbiter_alu #(.DWIDTH(DWIDTH)) u_alu (
        .sel    (alu_sel),
        .a      (alu_a),
        .b      (alu_b),
        .result (alu_result)
    );

    // Response registers, grant counters and round-robin pointer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp0_valid <= 1'b0;
            rsp0_data  <= '0;
            rsp1_valid <= 1'b0;
            rsp1_data  <= '0;
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
            prio       <= 1'b0;
        end else begin
            if (grant0) begin
                rsp0_valid <= 1'b1;
                rsp0_data  <= alu_result;
                grant_cnt0 <= grant_cnt0 + 16'd1;
            end else if (rsp0_ready) begin
                rsp0_valid <= 1'b0;
            end

            if (grant1) begin
                rsp1_valid <= 1'b1;
                rsp1_data  <= alu_result;
                grant_cnt1 <= grant_cnt1 + 16'd1;
            end else if (rsp1_ready) begin
                rsp1_valid <= 1'b0;
            end

            if (grant0) begin
                prio <= 1'b1;
            end else if (grant1) begin
                prio <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - self-checking bench for alu_arbiter against a behavioural model

module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req0_ready, rsp0_valid, rsp0_ready;
    logic [3:0]  req0_sel;
    logic [31:0] req0_a, req0_b, rsp0_data;
    logic        req1_valid, req1_ready, rsp1_valid, rsp1_ready;
    logic [3:0]  req1_sel;
    logic [31:0] req1_a, req1_b, rsp1_data;
    logic [15:0] grant_cnt0, grant_cnt1;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: held results, grant totals and which port won most recently.
    bit          m_valid [2];
    logic [31:0] m_data  [2];
    int          m_cnt   [2];
    int          last_win;
    bit          g0, g1;

    alu_arbiter #(.DWIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_sel   (req0_sel),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .rsp0_valid (rsp0_valid),
        .rsp0_ready (rsp0_ready),
        .rsp0_data  (rsp0_data),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_sel   (req1_sel),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .rsp1_valid (rsp1_valid),
        .rsp1_ready (rsp1_ready),
        .rsp1_data  (rsp1_data),
        .grant_cnt0 (grant_cnt0),
        .grant_cnt1 (grant_cnt1)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference ALU written from the operation table with explicit range handling.
    function automatic logic [31:0] alu_ref(input logic [3:0] s, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (s[2:0])
            3'd0: return s[3] ? 32'(a - b) : 32'(a + b);
            3'd1: return (b >= 32) ? 32'd0 : 32'(a * (33'd1 << b));
            3'd2: return (sa < sb) ? 32'd1 : 32'd0;
            3'd3: return ({32'd0, a} < {32'd0, b}) ? 32'd1 : 32'd0;
            3'd4: return a ^ b;
            3'd5: begin
                if (!s[3] || !a[31]) return (b >= 32) ? 32'd0 : a / (32'd1 << b);
                return (b >= 32) ? 32'hFFFF_FFFF : ~((~a) / (32'd1 << b));
            end
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    // One clock: check the combinational grant, advance the model, check the registered state.
    task automatic step();
        bit e0, e1;
        logic [31:0] r0, r1;
        #1;
        e0 = rst_n && req0_valid && (!m_valid[0] || rsp0_ready);
        e1 = rst_n && req1_valid && (!m_valid[1] || rsp1_ready);
        g0 = e0 && (!e1 || last_win == 1);
        g1 = e1 && (!e0 || last_win == 0);
        chk("req0_ready", req0_ready, g0);
        chk("req1_ready", req1_ready, g1);
        r0 = alu_ref(req0_sel, req0_a, req0_b);
        r1 = alu_ref(req1_sel, req1_a, req1_b);
        @(posedge clk);
        if (!rst_n) begin
            m_valid = '{0, 0};
            m_data  = '{32'd0, 32'd0};
            m_cnt   = '{0, 0};
            last_win = 1;
        end else begin
            if (g0) begin m_valid[0] = 1; m_data[0] = r0; m_cnt[0]++; last_win = 0; end
            else if (rsp0_ready) m_valid[0] = 0;
            if (g1) begin m_valid[1] = 1; m_data[1] = r1; m_cnt[1]++; last_win = 1; end
            else if (rsp1_ready) m_valid[1] = 0;
        end
        @(negedge clk);
        chk("rsp0_valid", rsp0_valid, m_valid[0]);
        chk("rsp0_data", rsp0_data, m_data[0]);
        chk("rsp1_valid", rsp1_valid, m_valid[1]);
        chk("rsp1_data", rsp1_data, m_data[1]);
        chk("grant_cnt0", grant_cnt0, 32'(m_cnt[0] & 16'hFFFF));
        chk("grant_cnt1", grant_cnt1, 32'(m_cnt[1] & 16'hFFFF));
    endtask

    task automatic drive0(input logic v, input logic [3:0] s, input logic [31:0] a, input logic [31:0] b);
        req0_valid = v; req0_sel = s; req0_a = a; req0_b = b;
    endtask

    task automatic drive1(input logic v, input logic [3:0] s, input logic [31:0] a, input logic [31:0] b);
        req1_valid = v; req1_sel = s; req1_a = a; req1_b = b;
    endtask

    initial begin
        int c0, c1;
        logic [31:0] rb;
        last_win = 1;
        m_valid = '{0, 0};
        m_data  = '{32'd0, 32'd0};
        m_cnt   = '{0, 0};
        rst_n = 1'b0;
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        drive0(1, 4'h0, 32'd1, 32'd1);
        drive1(1, 4'h0, 32'd2, 32'd2);

        // Reset with both requests present: no grants, everything cleared.
        step();
        step();
        chk("reset_ready0", {31'd0, req0_ready}, 32'd0);

        // Single add on port 0.
        rst_n = 1'b1;
        drive0(1, 4'b0000, 32'd5, 32'd3);
        drive1(0, 4'h0, 32'd0, 32'd0);
        step();
        chk("add_grant0", {31'd0, g0}, 32'd1);
        chk("add_data", rsp0_data, 32'd8);
        chk("add_cnt0", {16'd0, grant_cnt0}, 32'd1);

        // Port 1 arithmetic then logical right shift.
        drive0(0, 4'h0, 32'd0, 32'd0);
        drive1(1, 4'b1101, 32'h8000_0000, 32'd4);
        step();
        chk("sra_data", rsp1_data, 32'hF800_0000);
        drive1(1, 4'b0101, 32'h8000_0000, 32'd4);
        step();
        chk("srl_data", rsp1_data, 32'h0800_0000);

        // Both requesting: strict alternation starting from port 0.
        c0 = m_cnt[0];
        c1 = m_cnt[1];
        for (int i = 0; i < 6; i++) begin
            drive0(1, 4'($urandom), $urandom, $urandom_range(0, 40));
            drive1(1, 4'($urandom), $urandom, $urandom_range(0, 40));
            step();
            chk("alt_grant0", {31'd0, g0}, (i % 2 == 0) ? 32'd1 : 32'd0);
        end
        chk("alt_cnt0", 32'(grant_cnt0) - 32'(c0), 32'd3);
        chk("alt_cnt1", 32'(grant_cnt1) - 32'(c1), 32'd3);

        // Backpressure on port 0 while port 1 keeps flowing.
        drive1(0, 4'h0, 32'd0, 32'd0);
        drive0(1, 4'b1000, 32'd3, 32'd5);
        rsp0_ready = 1'b0;
        step();
        chk("bp_data", rsp0_data, 32'hFFFF_FFFE);
        for (int i = 0; i < 3; i++) begin
            drive0(1, 4'($urandom), $urandom, $urandom);
            drive1(1, 4'($urandom), $urandom, $urandom);
            step();
            chk("bp_ready0", {31'd0, g0}, 32'd0);
            chk("bp_grant1", {31'd0, g1}, 32'd1);
            chk("bp_hold", rsp0_data, 32'hFFFF_FFFE);
        end
        rsp0_ready = 1'b1;
        drive0(1, 4'b0000, 32'd1, 32'd1);
        drive1(0, 4'h0, 32'd0, 32'd0);
        step();
        chk("bp_refill", rsp0_data, 32'd2);

        // Signed vs unsigned compare.
        drive0(1, 4'b0010, 32'hFFFF_FFFF, 32'd1);
        step();
        chk("slt", rsp0_data, 32'd1);
        drive0(1, 4'b0011, 32'hFFFF_FFFF, 32'd1);
        step();
        chk("sltu", rsp0_data, 32'd0);

        // Random traffic with random consumer backpressure and occasional reset.
        for (int i = 0; i < 400; i++) begin
            rst_n = ($urandom_range(0, 59) != 0);
            rb = $urandom_range(0, 1) ? $urandom_range(0, 40) : $urandom;
            drive0($urandom_range(0, 3) != 0, 4'($urandom), $urandom, rb);
            rb = $urandom_range(0, 1) ? $urandom_range(0, 40) : $urandom;
            drive1($urandom_range(0, 3) != 0, 4'($urandom), $urandom, rb);
            rsp0_ready = ($urandom_range(0, 2) != 0);
            rsp1_ready = ($urandom_range(0, 2) != 0);
            step();
        end

        // Reset while port 1 holds a result and both requests wait.
        rst_n = 1'b1;
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b0;
        drive0(0, 4'h0, 32'd0, 32'd0);
        drive1(1, 4'b0110, 32'h0F0, 32'h00F);
        step();
        chk("pre_rst_valid1", {31'd0, rsp1_valid}, 32'd1);
        drive0(1, 4'h0, 32'd7, 32'd7);
        rst_n = 1'b0;
        step();
        chk("rst_valid1", {31'd0, rsp1_valid}, 32'd0);
        chk("rst_cnt0", {16'd0, grant_cnt0}, 32'd0);
        rst_n = 1'b1;
        rsp1_ready = 1'b1;
        step();
        chk("post_rst_grant0", {31'd0, g0}, 32'd1);
        chk("post_rst_data", rsp0_data, 32'd14);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
